// File: rtl/modred_sched_pkg.sv
// Shared constants and helpers for the modular-reduction scheduler.
// The word-size constants mirror the project-wide arithmetic configuration;
// the reduction chain spends 3 register stages per machine word.
package modred_sched_pkg;

   localparam int DATA_SIZE_ARB = 24;
   localparam int W_SIZE        = 8;
   localparam int MODRED_LAT    = 3 * (DATA_SIZE_ARB / W_SIZE);

   // Action taken by the outstanding-operation counter in one cycle
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   // An accept and a return in the same cycle cancel out
   function automatic cnt_op_e cnt_op(input logic xfer, input logic ret);
      cnt_op_e op;
      op = CNT_HOLD;
      if (xfer && !ret) op = CNT_INC;
      else if (!xfer && ret) op = CNT_DEC;
      return op;
   endfunction

endpackage

// File: rtl/modred_sched_arb.sv
// Combinational round-robin grant: first valid requester scanning cyclically
// from last+1. The pointer register lives in the parent.
module modred_rr_arb
   import modred_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] in_valid,
   input  logic [ID_W-1:0]    last,
   input  logic               drain,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    gnt_id
);

   logic            found;
   int              idx_int;
   logic [ID_W-1:0] idx;

   // Scan last+1, last+2, ... wrapping; drain suppresses the grant but not the scan
   always_comb begin
      grant   = '0;
      gnt_id  = '0;
      found   = 1'b0;
      idx_int = 0;
      idx     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_int = (int'(last) + k) % NUM_REQ;
         idx     = ID_W'(idx_int);
         if (!found && in_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = ~drain;
            gnt_id     = idx;
         end
      end
   end

endmodule

// File: rtl/modred_sched.sv
// Round-robin scheduler feeding one fixed-latency, non-stallable modular
// reduction chain. Requester IDs ride a tag pipeline matched to the chain
// latency so each result returns with its owner.
module modred_sched
   import modred_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 2 * DATA_SIZE_ARB,
   parameter int OUT_W   = DATA_SIZE_ARB,
   parameter int LAT     = MODRED_LAT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         in_valid,
   input  logic [NUM_REQ*IN_W-1:0]    in_data,
   output logic [NUM_REQ-1:0]         in_ready,
   input  logic                       drain,
   output logic [IN_W-1:0]            dp_in,
   input  logic [OUT_W-1:0]           dp_out,
   output logic                       out_valid,
   output logic [$clog2(NUM_REQ)-1:0] out_id,
   output logic [OUT_W-1:0]           out_data,
   output logic                       idle
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(LAT + 3);

   logic [NUM_REQ-1:0]       gnt;
   logic [ID_W-1:0]          gnt_id;
   logic                     xfer;

   logic [ID_W-1:0]          last_q,      last_d;
   logic [IN_W-1:0]          dp_in_q,     dp_in_d;
   logic [LAT:0]             tag_vld_q,   tag_vld_d;
   logic [LAT:0][ID_W-1:0]   tag_id_q,    tag_id_d;
   logic                     out_valid_q, out_valid_d;
   logic [ID_W-1:0]          out_id_q,    out_id_d;
   logic [OUT_W-1:0]         out_data_q,  out_data_d;
   logic [CNT_W-1:0]         inflight_q,  inflight_d;

   modred_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .in_valid (in_valid),
      .last     (last_q),
      .drain    (drain),
      .grant    (gnt),
      .gnt_id   (gnt_id)
   );

   assign in_ready  = gnt;
   assign xfer      = |(in_valid & gnt);
   assign dp_in     = dp_in_q;
   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_data  = out_data_q;
   assign idle      = (inflight_q == '0);

   // Next-state: pointer/operand capture, tag shift, result capture, outstanding count
   always_comb begin
      last_d  = last_q;
      dp_in_d = dp_in_q;   // held, not zeroed, when idle to avoid toggling the chain
      if (xfer) begin
         last_d = gnt_id;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) dp_in_d = in_data[i*IN_W +: IN_W];
         end
      end

      // Tag entry 0 lines up with dp_in; entry LAT lines up with dp_out
      tag_vld_d = {tag_vld_q[LAT-1:0], xfer};
      tag_id_d  = {tag_id_q[LAT-1:0], gnt_id};

      out_valid_d = tag_vld_q[LAT];
      out_id_d    = tag_vld_q[LAT] ? tag_id_q[LAT] : out_id_q;
      out_data_d  = tag_vld_q[LAT] ? dp_out        : out_data_q;

      case (cnt_op(xfer, out_valid_q))
         CNT_INC: inflight_d = inflight_q + CNT_W'(1);
         CNT_DEC: inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // State registers; reset discards every in-flight tag so stale chain data never surfaces
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q      <= ID_W'(NUM_REQ - 1);
         dp_in_q     <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         inflight_q  <= '0;
      end else begin
         last_q      <= last_d;
         dp_in_q     <= dp_in_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_data_q  <= out_data_d;
         inflight_q  <= inflight_d;
      end
   end

endmodule

// File: tb/tb_modred_sched.sv
// Directed bench for modred_sched with a stub reduction chain:
// a 9-stage delay line returning dp_in[23:0] ^ 'h5A.
module tb_modred_sched;

   localparam int NUM_REQ = 4;
   localparam int IN_W    = 48;
   localparam int OUT_W   = 24;
   localparam int LAT     = 9;
   localparam int ID_W    = 2;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b1;
   logic [NUM_REQ-1:0]      in_valid = '0;
   logic [NUM_REQ*IN_W-1:0] in_data = '0;
   logic [NUM_REQ-1:0]      in_ready;
   logic                    drain = 1'b0;
   logic [IN_W-1:0]         dp_in;
   logic [OUT_W-1:0]        dp_out;
   logic                    out_valid;
   logic [ID_W-1:0]         out_id;
   logic [OUT_W-1:0]        out_data;
   logic                    idle;

   logic [OUT_W-1:0]        chain [LAT];

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   modred_sched #(
      .NUM_REQ (NUM_REQ),
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .LAT     (LAT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .drain     (drain),
      .dp_in     (dp_in),
      .dp_out    (dp_out),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data),
      .idle      (idle)
   );

   // Stub reduction chain: LAT register stages, no reset
   always_ff @(posedge clk) begin
      chain[0] <= dp_in[OUT_W-1:0];
      for (int k = 1; k < LAT; k++) chain[k] <= chain[k-1];
   end
   assign dp_out = chain[LAT-1] ^ 24'h5A;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_n  = 1'b0;
      in_valid = '0;
      drain    = 1'b0;
      in_data  = '0;
      repeat (2) tick();
      reset_n  = 1'b1;
   endtask

   // Every slot gets a distinct value per cycle so the granted one is identifiable
   task automatic load_slots(input int k);
      for (int i = 0; i < NUM_REQ; i++)
         in_data[i*IN_W +: IN_W] = IN_W'(32'hA00 + 16*k + i);
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      in_valid = 4'b0100;
      #1;
      vec++; if (in_ready !== 4'b0100) begin err++; $display("FAIL reset_in_ready got %b want %b", in_ready, 4'b0100); end
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vec++; if (idle !== 1'b1) begin err++; $display("FAIL reset_idle got %b want 1", idle); end
      vec++; if (dp_in !== '0) begin err++; $display("FAIL reset_dp_in got %h want 0", dp_in); end
      vec++; if (out_data !== '0) begin err++; $display("FAIL reset_out_data got %h want 0", out_data); end
      vec++; if (out_id !== '0) begin err++; $display("FAIL reset_out_id got %0d want 0", out_id); end
      in_valid = 4'b0000;
      #1;
      vec++; if (in_ready !== 4'b0000) begin err++; $display("FAIL reset_in_ready_idle got %b want 0000", in_ready); end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         vec++; if (idle !== 1'b1 || out_valid !== 1'b0) begin err++; $display("FAIL single_pre c=%0d got idle=%b ov=%b want idle=1 ov=0", c, idle, out_valid); end
         tick();
      end
      in_valid = 4'b0100;
      in_data[2*IN_W +: IN_W] = 48'h1234;
      #1;
      vec++; if (in_ready !== 4'b0100) begin err++; $display("FAIL single_ready got %b want 0100", in_ready); end
      tick();
      in_valid = '0;
      for (int k = 1; k <= 12; k++) begin
         vec++; if (out_valid !== (k == 11)) begin err++; $display("FAIL single_ov k=%0d got %b want %b", k, out_valid, (k == 11)); end
         if (k == 11) begin
            vec++; if (out_id !== 2'd2) begin err++; $display("FAIL single_id got %0d want 2", out_id); end
            vec++; if (out_data !== 24'h00126E) begin err++; $display("FAIL single_data got %h want 00126e", out_data); end
         end
         vec++; if (idle !== (k >= 12)) begin err++; $display("FAIL single_idle k=%0d got %b want %b", k, idle, (k >= 12)); end
         tick();
      end
   endtask

   task automatic test_all_four;
      logic [3:0]       exp_r;
      logic [ID_W-1:0]  exp_id;
      logic [OUT_W-1:0] exp_d;
      int               j;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         in_valid = 4'b1111;
         load_slots(k);
         #1;
         exp_r = 4'(1 << (k % 4));
         vec++; if (in_ready !== exp_r) begin err++; $display("FAIL rr4_ready k=%0d got %b want %b", k, in_ready, exp_r); end
         tick();
      end
      in_valid = '0;
      for (int k = 8; k < 20; k++) begin
         if (k == 8 || k == 10) begin
            vec++; if (dut.inflight_q !== 4'd8) begin err++; $display("FAIL rr4_peak k=%0d got %0d want 8", k, dut.inflight_q); end
         end
         vec++; if (out_valid !== (k >= 11 && k <= 18)) begin err++; $display("FAIL rr4_ov k=%0d got %b want %b", k, out_valid, (k >= 11 && k <= 18)); end
         if (k >= 11 && k <= 18) begin
            j      = k - 11;
            exp_id = ID_W'(j % 4);
            exp_d  = OUT_W'(32'hA00 + 16*j + (j % 4)) ^ 24'h5A;
            vec++; if (out_id !== exp_id) begin err++; $display("FAIL rr4_id k=%0d got %0d want %0d", k, out_id, exp_id); end
            vec++; if (out_data !== exp_d) begin err++; $display("FAIL rr4_data k=%0d got %h want %h", k, out_data, exp_d); end
         end
         tick();
      end
      vec++; if (idle !== 1'b1 || dut.inflight_q !== 4'd0) begin err++; $display("FAIL rr4_end got idle=%b cnt=%0d want idle=1 cnt=0", idle, dut.inflight_q); end
   endtask

   task automatic test_alternate;
      logic [3:0]       exp_r;
      logic [ID_W-1:0]  exp_id;
      logic [OUT_W-1:0] exp_d;
      int               j;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         in_valid = 4'b1010;
         load_slots(k);
         #1;
         exp_r = (k % 2 == 0) ? 4'b0010 : 4'b1000;
         vec++; if (in_ready !== exp_r) begin err++; $display("FAIL alt_ready k=%0d got %b want %b", k, in_ready, exp_r); end
         if (k >= 11) begin
            j      = k - 11;
            exp_id = (j % 2 == 0) ? 2'd1 : 2'd3;
            exp_d  = OUT_W'(32'hA00 + 16*j + int'(exp_id)) ^ 24'h5A;
            vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL alt_ov k=%0d got %b want 1", k, out_valid); end
            vec++; if (out_id !== exp_id) begin err++; $display("FAIL alt_id k=%0d got %0d want %0d", k, out_id, exp_id); end
            vec++; if (out_data !== exp_d) begin err++; $display("FAIL alt_data k=%0d got %h want %h", k, out_data, exp_d); end
            vec++; if (dut.inflight_q !== 4'd11) begin err++; $display("FAIL alt_inflight k=%0d got %0d want 11", k, dut.inflight_q); end
         end
         tick();
      end
      in_valid = '0;
   endtask

   task automatic test_drain;
      logic [3:0] exp_r;
      int         nres;
      nres = 0;
      do_reset();
      for (int k = 0; k < 17; k++) begin
         in_valid = 4'b1111;
         drain    = (k >= 3);
         load_slots(k);
         #1;
         exp_r = (k < 3) ? 4'(1 << k) : 4'b0000;
         vec++; if (in_ready !== exp_r) begin err++; $display("FAIL drain_ready k=%0d got %b want %b", k, in_ready, exp_r); end
         vec++; if (out_valid !== (k >= 11 && k <= 13)) begin err++; $display("FAIL drain_ov k=%0d got %b want %b", k, out_valid, (k >= 11 && k <= 13)); end
         if (out_valid === 1'b1) nres++;
         if (k >= 11 && k <= 13) begin
            vec++; if (out_id !== ID_W'(k - 11)) begin err++; $display("FAIL drain_id k=%0d got %0d want %0d", k, out_id, k - 11); end
         end
         vec++; if (idle !== (k == 0 || k >= 14)) begin err++; $display("FAIL drain_idle k=%0d got %b want %b", k, idle, (k == 0 || k >= 14)); end
         tick();
      end
      vec++; if (nres !== 3) begin err++; $display("FAIL drain_count got %0d want 3", nres); end
      drain    = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_reset_midflight;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         in_valid = 4'b1111;
         load_slots(k);
         tick();
      end
      in_valid = '0;
      reset_n  = 1'b0;
      tick();
      reset_n  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL midrst_ov k=%0d got %b want 0", k, out_valid); end
         tick();
      end
      vec++; if (dut.inflight_q !== 4'd0 || idle !== 1'b1) begin err++; $display("FAIL midrst_idle got cnt=%0d idle=%b want 0/1", dut.inflight_q, idle); end
      in_valid = 4'b1111;
      #1;
      vec++; if (in_ready !== 4'b0001) begin err++; $display("FAIL midrst_next got %b want 0001", in_ready); end
      in_valid = '0;
      tick();
   endtask

   task automatic test_drop;
      do_reset();
      in_valid = 4'b0001;
      #1;
      vec++; if (in_ready !== 4'b0001) begin err++; $display("FAIL drop_first got %b want 0001", in_ready); end
      tick();
      in_valid = 4'b0100;
      #1;
      vec++; if (in_ready !== 4'b0100) begin err++; $display("FAIL drop_offer got %b want 0100", in_ready); end
      in_valid = 4'b0000;
      #1;
      vec++; if (in_ready !== 4'b0000) begin err++; $display("FAIL drop_gone got %b want 0000", in_ready); end
      tick();
      in_valid = 4'b1111;
      #1;
      vec++; if (in_ready !== 4'b0010) begin err++; $display("FAIL drop_next got %b want 0010", in_ready); end
      vec++; if (dut.inflight_q !== 4'd1) begin err++; $display("FAIL drop_inflight got %0d want 1", dut.inflight_q); end
      in_valid = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_alternate();
      test_drain();
      test_reset_midflight();
      test_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
